// File: rtl/fm_radio_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the FM demodulator datapath.
package fm_radio_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int QUANT_BITS = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MULT  = 3'd1,
        S_SUM   = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    // Arithmetic shift right that rounds toward zero instead of toward minus infinity.
    function automatic logic signed [DATA_WIDTH-1:0] DEQUANTIZE(input logic signed [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH-1:0] biased;
        if (v < 32'sd0) begin
            biased = v + ((32'sd1 <<< QUANT_BITS) - 32'sd1);
        end else begin
            biased = v;
        end
        return biased >>> QUANT_BITS;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] QUANTIZE(input logic signed [DATA_WIDTH-1:0] v);
        return v <<< QUANT_BITS;
    endfunction

endpackage

// File: rtl/fm_demod_conj_mult.sv
// FM discriminator front half: pops one I/Q pair, forms conj(prev)*cur in fixed point
// and offers (x,y) to the arctangent stage, holding them until that stage has sampled them.
module fm_demod_conj_mult
    import fm_radio_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] i_in,
    input  logic signed [DATA_WIDTH-1:0] q_in,
    input  logic                         i_empty,
    input  logic                         q_empty,
    output logic                         in_rd_en,
    output logic signed [DATA_WIDTH-1:0] x_out,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic                         demod_data_valid,
    input  logic                         divider_ready,
    input  logic                         qarctan_done
);

    state_t state_r;
    state_t next_state_s;

    logic signed [DATA_WIDTH-1:0] cur_i_r;
    logic signed [DATA_WIDTH-1:0] cur_q_r;
    logic signed [DATA_WIDTH-1:0] prev_i_r;
    logic signed [DATA_WIDTH-1:0] prev_q_r;
    logic signed [DATA_WIDTH-1:0] p_ii_r;
    logic signed [DATA_WIDTH-1:0] p_qq_r;
    logic signed [DATA_WIDTH-1:0] p_iq_r;
    logic signed [DATA_WIDTH-1:0] p_qi_r;

    // Next-state decode and the single-cycle FIFO pop strobe.
    always_comb begin
        next_state_s = state_r;
        in_rd_en     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!i_empty && !q_empty && !reset) begin
                    in_rd_en     = 1'b1;
                    next_state_s = S_MULT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_MULT:  next_state_s = S_SUM;
            S_SUM:   next_state_s = S_ISSUE;
            S_ISSUE: begin
                if (divider_ready) begin
                    next_state_s = S_WAIT;
                end else begin
                    next_state_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (qarctan_done) begin
                    next_state_s = S_HOLD;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_HOLD:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State, sample history, product pipeline and registered x/y/valid outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= S_IDLE;
            cur_i_r          <= 32'sd0;
            cur_q_r          <= 32'sd0;
            prev_i_r         <= 32'sd0;
            prev_q_r         <= 32'sd0;
            p_ii_r           <= 32'sd0;
            p_qq_r           <= 32'sd0;
            p_iq_r           <= 32'sd0;
            p_qi_r           <= 32'sd0;
            x_out            <= 32'sd0;
            y_out            <= 32'sd0;
            demod_data_valid <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            demod_data_valid <= (next_state_s == S_ISSUE);
            case (state_r)
                S_IDLE: begin
                    if (in_rd_en) begin
                        cur_i_r <= i_in;
                        cur_q_r <= q_in;
                    end
                end
                S_MULT: begin
                    // Only the low word of each 32x32 product is kept.
                    p_ii_r <= prev_i_r * cur_i_r;
                    p_qq_r <= prev_q_r * cur_q_r;
                    p_iq_r <= prev_i_r * cur_q_r;
                    p_qi_r <= prev_q_r * cur_i_r;
                end
                S_SUM: begin
                    x_out <= DEQUANTIZE(p_ii_r) + DEQUANTIZE(p_qq_r);
                    y_out <= DEQUANTIZE(p_iq_r) - DEQUANTIZE(p_qi_r);
                end
                S_HOLD: begin
                    prev_i_r <= cur_i_r;
                    prev_q_r <= cur_q_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_demod_conj_mult.sv
// Randomized self-checking bench for fm_demod_conj_mult against a plain-arithmetic model.
module tb_fm_demod_conj_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_in;
    logic [31:0] q_in;
    logic        i_empty;
    logic        q_empty;
    logic        in_rd_en;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic        demod_data_valid;
    logic        divider_ready;
    logic        qarctan_done;

    int vectors = 0;
    int miscompares = 0;
    int m_prev_i = 0;
    int m_prev_q = 0;

    always #5 clk = ~clk;

    fm_demod_conj_mult dut (
        .clk              (clk),
        .reset            (reset),
        .i_in             (i_in),
        .q_in             (q_in),
        .i_empty          (i_empty),
        .q_empty          (q_empty),
        .in_rd_en         (in_rd_en),
        .x_out            (x_out),
        .y_out            (y_out),
        .demod_data_valid (demod_data_valid),
        .divider_ready    (divider_ready),
        .qarctan_done     (qarctan_done)
    );

    // Integer division truncates toward zero, which is exactly the required rounding.
    function automatic int dq(input int v);
        return v / 1024;
    endfunction

    function automatic int mul32(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p[31:0]);
    endfunction

    // One full transaction: optional one-FIFO-empty wait, pop, pipeline, stalled issue,
    // wait for done, hold. Optionally aborts with reset while waiting for done.
    task automatic do_sample(input int si, input int sq, input int q_empty_cycles,
                             input int ready_low, input int done_delay, input bit abort_in_wait);
        int ex, ey;
        ex = dq(mul32(m_prev_i, si)) + dq(mul32(m_prev_q, sq));
        ey = dq(mul32(m_prev_i, sq)) - dq(mul32(m_prev_q, si));

        i_in = si;
        q_in = sq;
        i_empty = 1'b0;
        q_empty = 1'b1;
        for (int k = 0; k < q_empty_cycles; k++) begin
            #1;
            vectors++;
            if (in_rd_en !== 1'b0) begin
                $display("FAIL one_empty_no_pop: rd_en=%0b required 0", in_rd_en);
                miscompares++;
            end
            @(negedge clk);
        end
        q_empty = 1'b0;
        #1;
        vectors++;
        if (in_rd_en !== 1'b1) begin
            $display("FAIL pop: rd_en=%0b required 1", in_rd_en);
            miscompares++;
        end
        @(posedge clk);
        #1;
        i_empty = 1'b1;
        q_empty = 1'b1;

        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            vectors++;
            if (demod_data_valid !== 1'b0 || in_rd_en !== 1'b0) begin
                $display("FAIL latency_early(+%0d): valid=%0b rd_en=%0b required 0 0",
                         k, demod_data_valid, in_rd_en);
                miscompares++;
            end
        end

        // Stall with ready low; FIFOs look non-empty and done pulses, both must be ignored.
        i_empty = 1'b0;
        q_empty = 1'b0;
        qarctan_done = 1'b1;
        for (int k = 0; k <= ready_low; k++) begin
            @(negedge clk);
            if (k == ready_low) divider_ready = 1'b1;
            vectors++;
            if (demod_data_valid !== 1'b1 || x_out !== ex || y_out !== ey || in_rd_en !== 1'b0) begin
                $display("FAIL issue(%0d): valid=%0b x=%0d y=%0d rd_en=%0b required 1 %0d %0d 0",
                         k, demod_data_valid, $signed(x_out), $signed(y_out), in_rd_en, ex, ey);
                miscompares++;
            end
        end
        i_empty = 1'b1;
        q_empty = 1'b1;
        qarctan_done = 1'b0;
        @(posedge clk);
        #1;
        divider_ready = 1'b0;

        for (int k = 0; k <= done_delay; k++) begin
            @(negedge clk);
            vectors++;
            if (demod_data_valid !== 1'b0 || x_out !== ex || y_out !== ey) begin
                $display("FAIL wait(%0d): valid=%0b x=%0d y=%0d required 0 %0d %0d",
                         k, demod_data_valid, $signed(x_out), $signed(y_out), ex, ey);
                miscompares++;
            end
        end

        if (abort_in_wait) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(negedge clk);
            vectors++;
            if (demod_data_valid !== 1'b0 || x_out !== 32'd0 || y_out !== 32'd0 || in_rd_en !== 1'b0) begin
                $display("FAIL reset_in_wait: valid=%0b x=%0d y=%0d rd_en=%0b required 0 0 0 0",
                         demod_data_valid, $signed(x_out), $signed(y_out), in_rd_en);
                miscompares++;
            end
            m_prev_i = 0;
            m_prev_q = 0;
            return;
        end

        qarctan_done = 1'b1;
        @(posedge clk);
        #1;
        qarctan_done = 1'b0;
        @(negedge clk);
        vectors++;
        if (demod_data_valid !== 1'b0 || x_out !== ex || y_out !== ey || in_rd_en !== 1'b0) begin
            $display("FAIL hold: valid=%0b x=%0d y=%0d rd_en=%0b required 0 %0d %0d 0",
                     demod_data_valid, $signed(x_out), $signed(y_out), in_rd_en, ex, ey);
            miscompares++;
        end
        @(negedge clk);
        m_prev_i = si;
        m_prev_q = sq;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_in = 32'd7;
        q_in = 32'd9;
        i_empty = 1'b0;
        q_empty = 1'b0;
        divider_ready = 1'b0;
        qarctan_done = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_rd_en !== 1'b0 || demod_data_valid !== 1'b0 || x_out !== 32'd0 || y_out !== 32'd0) begin
            $display("FAIL reset_state: rd_en=%0b valid=%0b x=%0d y=%0d required 0 0 0 0",
                     in_rd_en, demod_data_valid, $signed(x_out), $signed(y_out));
            miscompares++;
        end
        i_empty = 1'b1;
        q_empty = 1'b1;
        reset = 1'b0;
        m_prev_i = 0;
        m_prev_q = 0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_sample(1024, 0, 0, 0, 0, 1'b0);
        do_sample(0, 1024, 0, 0, 1, 1'b0);
        do_sample(3, 0, 0, 0, 0, 1'b0);
        do_sample(-5, 0, 0, 0, 0, 1'b0);
        do_sample(1024, 0, 0, 0, 0, 1'b0);
        do_sample(-1, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_ready_stall();
        do_sample(int'($urandom_range(0, 100000)) - 50000, int'($urandom_range(0, 100000)) - 50000,
                  0, 20, 2, 1'b0);
    endtask

    task automatic test_one_empty();
        do_sample(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                  10, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int si, sq;
            if (n % 3 == 0) begin
                si = int'($urandom);
                sq = int'($urandom);
            end else begin
                si = int'($urandom_range(0, 131072)) - 65536;
                sq = int'($urandom_range(0, 131072)) - 65536;
            end
            do_sample(si, sq, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_reset_in_wait();
        do_sample(int'($urandom_range(1, 30000)), int'($urandom_range(1, 30000)), 0, 1, 1, 1'b0);
        do_sample(int'($urandom_range(1, 30000)), int'($urandom_range(1, 30000)), 0, 0, 2, 1'b1);
        // prev was cleared by the reset, so this transaction must yield zero.
        do_sample(int'($urandom_range(1, 30000)), int'($urandom_range(1, 30000)), 0, 0, 0, 1'b0);
        do_sample(int'($urandom_range(1, 30000)), -int'($urandom_range(1, 30000)), 0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ready_stall();
        test_one_empty();
        test_random();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
